// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit, single outstanding line fill.
// Miss stalls fetch through REQ/WAIT/FILL; memory response may take any number of WAIT cycles.
module icache #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int ILEN          = 32,
   parameter int LINE_WIDTH    = 128,
   parameter int NUM_LINES     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid_in,
   input  logic [ADDRESS_WIDTH-1:0] req_addr_in,
   output logic [ILEN-1:0]          instr_out,
   output logic                     hit_out,
   output logic                     stall_out,
   output logic                     mem_req_out,
   output logic [ADDRESS_WIDTH-1:0] mem_addr_out,
   input  logic                     mem_rsp_valid_in,
   input  logic [LINE_WIDTH-1:0]    mem_rsp_data_in
);

   localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
   localparam int BYTE_W = $clog2(ILEN / 8);
   localparam int WSEL_W = OFF_W - BYTE_W;
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDRESS_WIDTH - OFF_W - IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [NUM_LINES-1:0]     valid_q;
   logic [TAG_W-1:0]         tag_q  [NUM_LINES];
   logic [LINE_WIDTH-1:0]    data_q [NUM_LINES];

   logic [IDX_W-1:0]         req_idx, fill_idx;
   logic [TAG_W-1:0]         req_tag, fill_tag;
   logic [WSEL_W-1:0]        req_wsel;
   logic [LINE_WIDTH-1:0]    rd_line;
   logic [ILEN-1:0]          rd_word;
   logic                     lookup_hit;
   logic                     fill_we;
   logic                     unused_byte_bits;

   assign req_idx          = req_addr_in[OFF_W +: IDX_W];
   assign req_tag          = req_addr_in[ADDRESS_WIDTH-1 -: TAG_W];
   assign req_wsel         = req_addr_in[BYTE_W +: WSEL_W];
   assign fill_idx         = addr_q[OFF_W +: IDX_W];
   assign fill_tag         = addr_q[ADDRESS_WIDTH-1 -: TAG_W];
   assign unused_byte_bits = ^req_addr_in[BYTE_W-1:0];

   assign lookup_hit = req_valid_in && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign rd_line    = data_q[req_idx];
   assign rd_word    = rd_line[ILEN*req_wsel +: ILEN];
   assign fill_we    = (state_q == S_WAIT) && mem_rsp_valid_in;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_in && !lookup_hit) begin
               state_d = S_REQ;
               addr_d  = {req_addr_in[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            end
         end
         S_REQ:   state_d = S_WAIT;
         S_WAIT:  if (mem_rsp_valid_in) state_d = S_FILL;
         S_FILL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held so a stale valid line cannot report a hit.
   always_comb begin
      hit_out     = 1'b0;
      mem_req_out = 1'b0;
      stall_out   = 1'b1;
      case (state_q)
         S_IDLE: begin
            hit_out   = lookup_hit && !reset;
            stall_out = req_valid_in && !lookup_hit;
         end
         S_REQ:   mem_req_out = !reset;
         default: ;
      endcase
      instr_out    = hit_out ? rd_word : '0;
      mem_addr_out = reset ? '0 : addr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         addr_q  <= '0;
      end else begin
         addr_q <= addr_d;
         if (fill_we) valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (fill_we && !reset) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mem_rsp_data_in;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, same-line hits, eviction, address change, reset mid-fill.
module tb_icache;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid_in;
   logic [31:0]  req_addr_in;
   logic [31:0]  instr_out;
   logic         hit_out;
   logic         stall_out;
   logic         mem_req_out;
   logic [31:0]  mem_addr_out;
   logic         mem_rsp_valid_in;
   logic [127:0] mem_rsp_data_in;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [127:0] L0 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0013};
   localparam logic [127:0] L1 = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
   localparam logic [127:0] L2 = {32'hBBBB_0003, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};

   icache #(
      .ADDRESS_WIDTH(32), .ILEN(32), .LINE_WIDTH(128), .NUM_LINES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid_in(req_valid_in),
      .req_addr_in(req_addr_in),
      .instr_out(instr_out),
      .hit_out(hit_out),
      .stall_out(stall_out),
      .mem_req_out(mem_req_out),
      .mem_addr_out(mem_addr_out),
      .mem_rsp_valid_in(mem_rsp_valid_in),
      .mem_rsp_data_in(mem_rsp_data_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives a miss on miss_addr, moves the PC to wait_addr once in WAIT, returns data after wait_n WAIT cycles.
   task automatic do_fill(input logic [31:0] miss_addr, input logic [31:0] wait_addr,
                          input logic [127:0] line, input int wait_n);
      int stalls;
      stalls       = 0;
      req_valid_in = 1'b1;
      req_addr_in  = miss_addr;
      @(negedge clk);
      check("miss_hit", hit_out, 0);
      check("miss_stall", stall_out, 1);
      check("miss_memreq", mem_req_out, 0);
      stalls += int'(stall_out);
      step();
      @(negedge clk);
      check("req_memreq", mem_req_out, 1);
      check("req_addr", mem_addr_out, miss_addr & 32'hFFFF_FFF0);
      check("req_hit", hit_out, 0);
      stalls += int'(stall_out);
      step();
      req_addr_in = wait_addr;
      for (int i = 0; i < wait_n; i++) begin
         if (i == wait_n - 1) begin
            mem_rsp_valid_in = 1'b1;
            mem_rsp_data_in  = line;
         end
         @(negedge clk);
         check("wait_memreq", mem_req_out, 0);
         check("wait_addr", mem_addr_out, miss_addr & 32'hFFFF_FFF0);
         check("wait_hit", hit_out, 0);
         stalls += int'(stall_out);
         step();
      end
      mem_rsp_valid_in = 1'b0;
      mem_rsp_data_in  = '0;
      @(negedge clk);
      check("fill_hit", hit_out, 0);
      check("fill_memreq", mem_req_out, 0);
      stalls += int'(stall_out);
      check("stall_cycles", stalls, wait_n + 3);
      step();
   endtask

   initial begin
      logic [31:0] addrs [3];
      logic [31:0] words [3];
      addrs = '{32'h1004, 32'h1008, 32'h100C};
      words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

      reset            = 1'b1;
      req_valid_in     = 1'b1;
      req_addr_in      = 32'h1000;
      mem_rsp_valid_in = 1'b0;
      mem_rsp_data_in  = '0;
      step();
      @(negedge clk);
      check("rst_hit", hit_out, 0);
      check("rst_memreq", mem_req_out, 0);
      check("rst_addr", mem_addr_out, 0);
      check("rst_instr", instr_out, 0);
      req_valid_in = 1'b0;
      @(negedge clk);
      check("rst_stall_idle", stall_out, 0);
      step();
      reset = 1'b0;

      // Cold miss, response two cycles after REQ: five stall cycles then a hit.
      do_fill(32'h1000, 32'h1000, L0, 2);
      @(negedge clk);
      check("cold_hit", hit_out, 1);
      check("cold_instr", instr_out, 32'h0000_0013);
      check("cold_stall", stall_out, 0);
      step();

      for (int k = 0; k < 3; k++) begin
         req_addr_in = addrs[k];
         @(negedge clk);
         check("line_hit", hit_out, 1);
         check("line_instr", instr_out, words[k]);
         check("line_memreq", mem_req_out, 0);
         check("line_stall", stall_out, 0);
         step();
      end

      req_addr_in = 32'h1003;
      @(negedge clk);
      check("byte_ignored", instr_out, 32'h0000_0013);
      step();

      req_valid_in = 1'b0;
      @(negedge clk);
      check("noreq_stall", stall_out, 0);
      check("noreq_hit", hit_out, 0);
      step();

      // Spurious response in IDLE must not touch the array.
      req_valid_in     = 1'b1;
      req_addr_in      = 32'h1000;
      mem_rsp_valid_in = 1'b1;
      mem_rsp_data_in  = {128{1'b1}};
      @(negedge clk);
      check("spur_hit", hit_out, 1);
      step();
      mem_rsp_valid_in = 1'b0;
      mem_rsp_data_in  = '0;
      @(negedge clk);
      check("spur_hit_after", hit_out, 1);
      check("spur_instr", instr_out, 32'h0000_0013);
      check("spur_memreq", mem_req_out, 0);
      step();

      // Conflict eviction at index 0, minimum latency.
      do_fill(32'h1040, 32'h1040, L1, 1);
      @(negedge clk);
      check("evict_hit", hit_out, 1);
      check("evict_instr", instr_out, 32'hAAAA_0000);
      step();
      req_addr_in = 32'h1048;
      @(negedge clk);
      check("evict_w2", instr_out, 32'hAAAA_0002);
      step();
      do_fill(32'h1000, 32'h1000, L0, 1);
      @(negedge clk);
      check("refill_instr", instr_out, 32'h0000_0013);
      step();

      // PC changes during WAIT: fill still lands at the latched line.
      do_fill(32'h1040, 32'h1040, L1, 1);
      do_fill(32'h1000, 32'h2000, L0, 3);
      req_addr_in = 32'h1000;
      @(negedge clk);
      check("chg_old_hit", hit_out, 1);
      check("chg_old_instr", instr_out, 32'h0000_0013);
      step();
      do_fill(32'h2000, 32'h2000, L2, 1);
      @(negedge clk);
      check("chg_new_hit", hit_out, 1);
      check("chg_new_instr", instr_out, 32'hBBBB_0000);
      step();

      // Reset during WAIT abandons the fill; a late response is ignored.
      do_fill(32'h1040, 32'h1040, L1, 1);
      req_addr_in = 32'h1000;
      step();
      step();
      reset = 1'b1;
      @(negedge clk);
      check("rstw_memreq", mem_req_out, 0);
      check("rstw_addr", mem_addr_out, 0);
      check("rstw_hit", hit_out, 0);
      step();
      reset            = 1'b0;
      req_valid_in     = 1'b0;
      mem_rsp_valid_in = 1'b1;
      mem_rsp_data_in  = L0;
      @(negedge clk);
      check("late_rsp_stall", stall_out, 0);
      check("late_rsp_memreq", mem_req_out, 0);
      step();
      mem_rsp_valid_in = 1'b0;
      mem_rsp_data_in  = '0;
      do_fill(32'h1000, 32'h1000, L0, 1);
      @(negedge clk);
      check("post_rst_hit", hit_out, 1);
      check("post_rst_instr", instr_out, 32'h0000_0013);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter ADDRESS_WIDTH, 32, byte address width shared with the fetch stage.
REQ-002 Parameter ILEN, 32, instruction width.
REQ-003 Parameter LINE_WIDTH, 128, cache line width; four ILEN words per line.
REQ-004 Parameter NUM_LINES, 4, direct-mapped line count.
REQ-005 Port clk  in  1  sole clock; all state updates on posedge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port req_valid_in  in  1  fetch stage presents a PC this cycle.
REQ-008 Port req_addr_in  in  ADDRESS_WIDTH  fetch PC, byte address.
REQ-009 Port instr_out  out  ILEN  instruction word for req_addr_in; valid only when hit_out=1.
REQ-010 Port hit_out  out  1  instr_out valid this cycle.
REQ-011 Port stall_out  out  1  fetch stage must hold its PC.
REQ-012 Port mem_req_out  out  1  line-fill request to memory, one-cycle pulse.
REQ-013 Port mem_addr_out  out  ADDRESS_WIDTH  line-aligned fill address, low 4 bits zero.
REQ-014 Port mem_rsp_valid_in  in  1  fill data present this cycle.
REQ-015 Port mem_rsp_data_in  in  LINE_WIDTH  fill line; word k in bits [32k+31:32k].

Function
REQ-016 Address split: word select [3:2], index [5:4], tag [ADDRESS_WIDTH-1:6]; bits [1:0] ignored.
REQ-017 Per-line storage: valid bit, tag, LINE_WIDTH data.
REQ-018 FSM states: IDLE, REQ, WAIT, FILL.
REQ-019 Hit in IDLE: req_valid_in=1, line valid, tag match -> same cycle (combinational) hit_out=1, instr_out = selected word, stall_out=0.
REQ-020 Miss in IDLE: req_valid_in=1 and no hit -> hit_out=0, stall_out=1; latch line-aligned address; next state REQ.
REQ-021 REQ: mem_req_out=1 for exactly one cycle with latched mem_addr_out; next state WAIT.
REQ-022 WAIT: hold until mem_rsp_valid_in=1; mem_req_out=0; mem_addr_out held.
REQ-023 mem_rsp_valid_in in WAIT -> write data, tag, valid=1 into the latched index; next state FILL.
REQ-024 mem_rsp_valid_in outside WAIT is ignored; no state or array change.
REQ-025 FILL: one cycle, stall_out=1, hit_out=0; next state IDLE, where the held PC re-looks up and hits.
REQ-026 stall_out=1 in REQ, WAIT, FILL and on an IDLE miss; 0 otherwise, including IDLE with req_valid_in=0.
REQ-027 hit_out=0 in every state except IDLE.
REQ-028 Miss-to-hit latency: miss cycle, REQ, WAIT (>=1 cycle), FILL, then hit; minimum 4 stall cycles when data returns the cycle after REQ.
REQ-029 A fill, once begun, always completes to the latched address even if req_addr_in changes or req_valid_in drops.
REQ-030 A fill evicts the resident line at that index unconditionally; no write-back.
REQ-031 Exactly one outstanding fill; no new request until FILL completes.

Reset
REQ-032 reset=1 at posedge: state<=IDLE, all valid bits<=0, latched address<=0; tag and data arrays not cleared.
REQ-033 Outputs during and after reset: hit_out=0, mem_req_out=0, mem_addr_out=0, instr_out=0 when hit_out=0; stall_out follows REQ-026.
REQ-034 reset mid-fill (REQ/WAIT/FILL) abandons the fill; the line is not written; a late mem_rsp_valid_in is ignored per REQ-024.
REQ-035 reset has priority over every other event in the same cycle.

Verification
REQ-036 Cold miss: reset, req 0x1000, response 2 cycles after REQ with word0=0x00000013 -> mem_req_out pulse with addr 0x1000, stall_out=1 for 5 cycles, then hit_out=1, instr_out=0x00000013.
REQ-037 Same-line hits: after REQ-036, req 0x1004, 0x1008, 0x100C -> hit_out=1 each cycle, words 1..3, no mem_req_out.
REQ-038 Conflict eviction: req 0x1040 (same index 0, new tag) -> miss, fill; then req 0x1000 -> miss again.
REQ-039 Address change during WAIT: req_addr_in 0x1000 -> 0x2000 in WAIT -> line 0x1000 filled; in IDLE 0x2000 misses and issues fill at 0x2000.
REQ-040 Reset in WAIT, then mem_rsp_valid_in=1 -> no line written; following req 0x1000 misses.
REQ-041 Spurious mem_rsp_valid_in in IDLE -> arrays unchanged, hit_out unchanged.
